add_sub_multicycle: RTL and testbench

- Sequential, parametrised successor to the combinational adder/subtractor.
- Computes A+B+Cin or A+~B+Cin, CHUNK bits per clock. A single carry register links the chunks, so a wide datapath costs one narrow adder.
- Produces ARM-style NZCV flags, which the combinational version lacks. Supports carry-in for ADC/SBC, valid/ready handshakes on both sides, and a synchronous flush.
- Sits between the decode/issue stage and writeback of the processor ALU path.

---
 rtl/add_sub_multicycle.sv | 157 +++++++++++++++
 tb/tb_add_sub_multicycle.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_multicycle.sv
// Multi-cycle adder/subtractor: one CHUNK-bit adder walks the operands LSB-first
// through a carry register and emits ARM-style NZCV flags with valid/ready handshakes.
module add_sub_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             use_cin,
    input  logic             cin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("add_sub_multicycle: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One chunk of the ripple: returns {carry_out, sum}.
    function automatic logic [CHUNK:0] add_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_out_valid;
    logic             r_flag_n;
    logic             r_flag_z;
    logic             r_flag_c;
    logic             r_flag_v;

    logic [31:0]      w_shift;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum_full;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_c_into_msb;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_s_next;

    assign w_shift    = 32'(r_idx) * 32'(CHUNK);
    assign w_a_chunk  = CHUNK'(r_a >> w_shift);
    assign w_b_chunk  = CHUNK'(r_b >> w_shift);
    assign w_sum_full = add_chunk(w_a_chunk, w_b_chunk, r_carry);
    assign w_sum      = w_sum_full[CHUNK-1:0];
    assign w_cout     = w_sum_full[CHUNK];

    // Only meaningful on the last chunk, which always holds bit WIDTH-1.
    assign w_c_into_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];

    // Full result as it will look after this edge, so Z sees the final chunk too.
    assign w_mask   = WIDTH'({CHUNK{1'b1}}) << w_shift;
    assign w_s_next = (r_s & ~w_mask) | (WIDTH'(w_sum) << w_shift);

    assign in_ready  = (r_state == ST_IDLE) && !flush;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;

    // Control FSM plus operand, carry, result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= {IDXW{1'b0}};
            r_carry     <= 1'b0;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_s         <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_idx       <= {IDXW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= use_cin ? cin : sub;
                        r_idx   <= {IDXW{1'b0}};
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_s     <= w_s_next;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_flag_c    <= w_cout;
                        r_flag_v    <= w_c_into_msb ^ w_cout;
                        r_flag_n    <= w_s_next[WIDTH-1];
                        r_flag_z    <= (w_s_next == {WIDTH{1'b0}});
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_idx       <= {IDXW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_multicycle.sv
// Directed bench for add_sub_multicycle: main 32/8 instance plus 32/32 and 32/1 variants.
module tb_add_sub_multicycle;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        use_cin;
    logic        cin;
    logic        flush;
    logic        out_ready;

    logic        iv0, ir0, ov0, n0, z0, c0, v0;
    logic [31:0] s0;
    logic        iv32, ir32, ov32, n32, z32, c32, v32;
    logic [31:0] s32;
    logic        iv1, ir1, ov1, n1, z1, c1, v1;
    logic [31:0] s1;

    int          pass_cnt;
    int          total_cnt;
    logic [31:0] cap_s;
    logic [3:0]  cap_nzcv;
    int          lat;
    logic        ready_hi;

    add_sub_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
        .sub(sub), .use_cin(use_cin), .cin(cin), .flush(flush), .out_valid(ov0),
        .out_ready(out_ready), .s(s0), .flag_n(n0), .flag_z(z0), .flag_c(c0), .flag_v(v0)
    );

    add_sub_multicycle #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
        .sub(sub), .use_cin(use_cin), .cin(cin), .flush(flush), .out_valid(ov32),
        .out_ready(out_ready), .s(s32), .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
    );

    add_sub_multicycle #(.WIDTH(32), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .sub(sub), .use_cin(use_cin), .cin(cin), .flush(flush), .out_valid(ov1),
        .out_ready(out_ready), .s(s1), .flag_n(n1), .flag_z(z1), .flag_c(c1), .flag_v(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {in_ready, out_valid, N, Z, C, V, s} of the selected instance.
    function automatic logic [37:0] view(input int sel);
        case (sel)
            1:       view = {ir32, ov32, n32, z32, c32, v32, s32};
            2:       view = {ir1, ov1, n1, z1, c1, v1, s1};
            default: view = {ir0, ov0, n0, z0, c0, v0, s0};
        endcase
    endfunction

    // Issue one request, scramble inputs after accept, wait for out_valid.
    task automatic run_op(input int sel, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tsub, input logic tuc, input logic tcin);
        logic [37:0] v;
        @(negedge clk);
        a = ta; b = tb; sub = tsub; use_cin = tuc; cin = tcin;
        iv0 = (sel == 0); iv32 = (sel == 1); iv1 = (sel == 2);
        @(posedge clk);
        #1;
        iv0 = 1'b0; iv32 = 1'b0; iv1 = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; sub = ~tsub; cin = ~tcin; use_cin = ~tuc;
        lat = 0;
        v = view(sel);
        ready_hi = v[37];
        while (!v[36] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            v = view(sel);
            if (v[37]) ready_hi = 1'b1;
        end
        cap_s    = v[31:0];
        cap_nzcv = v[35:32];
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (ov0 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov0); else pass_cnt++;
        total_cnt++; if (s0 !== 32'h0) $display("FAIL reset_s got %h want 00000000", s0); else pass_cnt++;
        total_cnt++; if ({n0, z0, c0, v0} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {n0, z0, c0, v0}); else pass_cnt++;
        total_cnt++; if (ir0 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir0); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        run_op(0, 32'h5, 32'h3, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h8) $display("FAIL add_s got %h want 00000008", cap_s); else pass_cnt++;
        total_cnt++; if (cap_nzcv !== 4'b0000) $display("FAIL add_nzcv got %b want 0000", cap_nzcv); else pass_cnt++;
        total_cnt++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (ready_hi !== 1'b0) $display("FAIL add_in_ready_busy got %b want 0", ready_hi); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ir0 !== 1'b1) $display("FAIL add_in_ready_after got %b want 1", ir0); else pass_cnt++;
    endtask

    task automatic test_sub;
        run_op(0, 32'h5, 32'h5, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h0) $display("FAIL sub_eq_s got %h want 00000000", cap_s); else pass_cnt++;
        total_cnt++; if (cap_nzcv !== 4'b0110) $display("FAIL sub_eq_nzcv got %b want 0110", cap_nzcv); else pass_cnt++;
        run_op(0, 32'h3, 32'h5, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'hFFFF_FFFE) $display("FAIL sub_borrow_s got %h want fffffffe", cap_s); else pass_cnt++;
        total_cnt++; if (cap_nzcv !== 4'b1000) $display("FAIL sub_borrow_nzcv got %b want 1000", cap_nzcv); else pass_cnt++;
    endtask

    task automatic test_overflow;
        run_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h8000_0000) $display("FAIL ovf_s got %h want 80000000", cap_s); else pass_cnt++;
        total_cnt++; if (cap_nzcv !== 4'b1001) $display("FAIL ovf_nzcv got %b want 1001", cap_nzcv); else pass_cnt++;
        run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h0) $display("FAIL wrap_s got %h want 00000000", cap_s); else pass_cnt++;
        total_cnt++; if (cap_nzcv !== 4'b0110) $display("FAIL wrap_nzcv got %b want 0110", cap_nzcv); else pass_cnt++;
    endtask

    task automatic test_carry_in;
        run_op(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b1);
        total_cnt++; if (cap_s !== 32'h0) $display("FAIL adc_s got %h want 00000000", cap_s); else pass_cnt++;
        total_cnt++; if (cap_nzcv !== 4'b0110) $display("FAIL adc_nzcv got %b want 0110", cap_nzcv); else pass_cnt++;
        run_op(0, 32'd10, 32'd3, 1'b1, 1'b1, 1'b0);
        total_cnt++; if (cap_s !== 32'h6) $display("FAIL sbc_s got %h want 00000006", cap_s); else pass_cnt++;
        total_cnt++; if (cap_nzcv !== 4'b0010) $display("FAIL sbc_nzcv got %b want 0010", cap_nzcv); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic stable;
        out_ready = 1'b0;
        run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h2345_6789) $display("FAIL bp_s got %h want 23456789", cap_s); else pass_cnt++;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ov0 !== 1'b1 || s0 !== cap_s || {n0, z0, c0, v0} !== cap_nzcv) stable = 1'b0;
        end
        total_cnt++; if (stable !== 1'b1) $display("FAIL bp_hold got %b want 1", stable); else pass_cnt++;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (ov0 !== 1'b0) $display("FAIL bp_transfer got %b want 0", ov0); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (ov0 !== 1'b0 || s0 !== 32'h2345_6789) $display("FAIL bp_single got ov=%b s=%h want ov=0 s=23456789", ov0, s0); else pass_cnt++;
    endtask

    task automatic test_flush;
        logic seen_valid;
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; use_cin = 1'b0; iv0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        seen_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (ov0) seen_valid = 1'b1;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        total_cnt++; if (ir0 !== 1'b0) $display("FAIL flush_in_ready_low got %b want 0", ir0); else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        #1;
        total_cnt++; if (ir0 !== 1'b1) $display("FAIL flush_in_ready_after got %b want 1", ir0); else pass_cnt++;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ov0) seen_valid = 1'b1;
        end
        total_cnt++; if (seen_valid !== 1'b0) $display("FAIL flush_no_output got %b want 0", seen_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midrun;
        logic seen_valid;
        run_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; use_cin = 1'b0; iv0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (s0 !== 32'h0 || {n0, z0, c0, v0} !== 4'b0000) $display("FAIL rst_mid_outputs got s=%h nzcv=%b want 0", s0, {n0, z0, c0, v0}); else pass_cnt++;
        total_cnt++; if (ov0 !== 1'b0 || ir0 !== 1'b1) $display("FAIL rst_mid_handshake got ov=%b ir=%b want ov=0 ir=1", ov0, ir0); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ov0) seen_valid = 1'b1;
        end
        total_cnt++; if (seen_valid !== 1'b0 || s0 !== 32'h0) $display("FAIL rst_mid_discard got ov=%b s=%h want 0", seen_valid, s0); else pass_cnt++;
    endtask

    task automatic test_chunk_variants;
        run_op(1, 32'h5, 32'h3, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h8 || cap_nzcv !== 4'b0000) $display("FAIL chunk32_result got s=%h nzcv=%b want 00000008 0000", cap_s, cap_nzcv); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL chunk32_latency got %0d want 1", lat); else pass_cnt++;
        run_op(2, 32'h5, 32'h3, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h8 || cap_nzcv !== 4'b0000) $display("FAIL chunk1_result got s=%h nzcv=%b want 00000008 0000", cap_s, cap_nzcv); else pass_cnt++;
        total_cnt++; if (lat !== 32) $display("FAIL chunk1_latency got %0d want 32", lat); else pass_cnt++;
        run_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (cap_s !== 32'h0 || cap_nzcv !== 4'b0110) $display("FAIL chunk1_wrap got s=%h nzcv=%b want 00000000 0110", cap_s, cap_nzcv); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        a = 32'h0; b = 32'h0; sub = 1'b0; use_cin = 1'b0; cin = 1'b0;
        iv0 = 1'b0; iv32 = 1'b0; iv1 = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_carry_in();
        test_backpressure();
        test_flush();
        test_reset_midrun();
        test_chunk_variants();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
